// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
// secded_pkg
// Shared sizing, position mapping, encode/syndrome/extract functions and
// classification codes for the pipelined SECDED codec.
// Revision: 1.0 - initial release
// ============================================================================
package secded_pkg;

    // Widest supported configuration; functions work on these widths and
    // callers cast to their actual sizes.
    localparam int MAX_DW = 64;
    localparam int MAX_R  = 7;
    localparam int MAX_N  = MAX_DW + MAX_R;
    localparam int MAX_CW = MAX_N + 1;

    // Classification encodings: bit 0 = corrected, bit 1 = uncorrectable
    localparam logic [1:0] CLS_CLEAN         = 2'b00;
    localparam logic [1:0] CLS_CORRECTED     = 2'b01;
    localparam logic [1:0] CLS_UNCORRECTABLE = 2'b10;

    // Smallest r with 2^r >= dw + r + 1
    function automatic int calc_r(input int dw);
        int r;
        r = 1;
        for (int k = 0; k <= MAX_R; k++) begin
            if ((1 << r) < dw + r + 1) r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p != 0) && ((p & (p - 1)) == 0);
    endfunction

    // Hamming position (1-based) that carries data bit idx
    function automatic int idx_to_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p <= MAX_N; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) pos = p;
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // Data bit index carried by Hamming position p (p must not be a power of 2)
    function automatic int pos_to_idx(input int p);
        int cnt;
        cnt = 0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k < p && !is_pow2(k)) cnt = cnt + 1;
        end
        return cnt;
    endfunction

    // Full SECDED codeword for the low dw bits of d
    function automatic logic [MAX_CW-1:0] encode(input logic [MAX_DW-1:0] d, input int dw);
        logic [MAX_CW-1:0] c;
        logic              par;
        int                r;
        int                n;
        c = '0;
        r = calc_r(dw);
        n = dw + r;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < dw) c[idx_to_pos(i)] = d[i];
        end
        // Parity slots are still zero here, so XOR over every position is safe
        for (int k = 0; k < MAX_R; k++) begin
            if (k < r) begin
                par = 1'b0;
                for (int p = 1; p <= MAX_N; p++) begin
                    if (p <= n && p[k]) par = par ^ c[p];
                end
                c[1 << k] = par;
            end
        end
        c[0] = ^c;
        return c;
    endfunction

    // XOR of the indices of all set Hamming positions 1..n
    function automatic logic [MAX_R-1:0] syndrome(input logic [MAX_CW-1:0] c, input int n);
        logic [MAX_R-1:0] s;
        s = '0;
        for (int p = 1; p < MAX_CW; p++) begin
            if (p <= n && c[p]) s = s ^ MAX_R'(p);
        end
        return s;
    endfunction

    // Gather data bits back out of their Hamming positions
    function automatic logic [MAX_DW-1:0] extract(input logic [MAX_CW-1:0] c, input int dw);
        logic [MAX_DW-1:0] d;
        d = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < dw) d[i] = c[idx_to_pos(i)];
        end
        return d;
    endfunction

    // Map syndrome s and overall parity q onto a classification code
    function automatic logic [1:0] classify(input logic [MAX_R-1:0] s, input logic q, input int n);
        if (!q) begin
            return (s == '0) ? CLS_CLEAN : CLS_UNCORRECTABLE;
        end
        if (s == '0 || s <= MAX_R'(n)) return CLS_CORRECTED;
        return CLS_UNCORRECTABLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded_codec_pipe_if.sv
`default_nettype none
// ============================================================================
// secded_codec_pipe_if
// Bundles the encode/decode handshakes, counter clear and statistics outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface secded_codec_pipe_if
    import secded_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    localparam int R  = calc_r(DATA_W);
    localparam int CW = DATA_W + R + 1;

    logic              enc_in_valid;
    logic              enc_in_ready;
    logic [DATA_W-1:0] enc_in_data;
    logic [CW-1:0]     enc_in_inject;
    logic              enc_out_valid;
    logic              enc_out_ready;
    logic [CW-1:0]     enc_out_code;

    logic              dec_in_valid;
    logic              dec_in_ready;
    logic [CW-1:0]     dec_in_code;
    logic              dec_out_valid;
    logic              dec_out_ready;
    logic [DATA_W-1:0] dec_out_data;
    logic [R-1:0]      dec_out_syndrome;
    logic              dec_out_corrected;
    logic              dec_out_uncorrectable;

    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    modport slave (
        input  enc_in_valid, enc_in_data, enc_in_inject, enc_out_ready,
        input  dec_in_valid, dec_in_code, dec_out_ready, cnt_clr,
        output enc_in_ready, enc_out_valid, enc_out_code,
        output dec_in_ready, dec_out_valid, dec_out_data, dec_out_syndrome,
        output dec_out_corrected, dec_out_uncorrectable, corr_cnt, uncorr_cnt
    );

    modport master (
        output enc_in_valid, enc_in_data, enc_in_inject, enc_out_ready,
        output dec_in_valid, dec_in_code, dec_out_ready, cnt_clr,
        input  enc_in_ready, enc_out_valid, enc_out_code,
        input  dec_in_ready, dec_out_valid, dec_out_data, dec_out_syndrome,
        input  dec_out_corrected, dec_out_uncorrectable, corr_cnt, uncorr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/secded_pipe_reg.sv
`default_nettype none
// ============================================================================
// secded_pipe_reg
// Single valid/ready register slice; ready passes through combinationally
// from downstream, valid never feeds ready.
// Revision: 1.0 - initial release
// ============================================================================
module secded_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign in_ready  = !r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Load a new word whenever the slot is empty or being drained; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) r_data <= in_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/secded_codec_pipe.sv
`default_nettype none
// ============================================================================
// secded_codec_pipe
// Pipelined SECDED encoder (1 stage) and decoder (2 stages) with independent
// valid/ready channels and saturating correction statistics.
// Revision: 1.0 - initial release
// ============================================================================
module secded_codec_pipe
    import secded_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    secded_codec_pipe_if.slave bus
);
    localparam int R    = calc_r(DATA_W);
    localparam int N    = DATA_W + R;
    localparam int CW   = N + 1;
    localparam int S1_W = CW + R + 1;      // {code, syndrome, overall parity}
    localparam int S2_W = DATA_W + R + 2;  // {data, syndrome, corrected, uncorrectable}

    // ---------------- encode channel ----------------
    logic [CW-1:0] w_enc_code;

    assign w_enc_code = CW'(encode(MAX_DW'(bus.enc_in_data), DATA_W)) ^ bus.enc_in_inject;

    secded_pipe_reg #(.WIDTH(CW)) u_enc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.enc_in_valid),
        .in_ready  (bus.enc_in_ready),
        .in_data   (w_enc_code),
        .out_valid (bus.enc_out_valid),
        .out_ready (bus.enc_out_ready),
        .out_data  (bus.enc_out_code)
    );

    // ---------------- decode stage 1: syndrome ----------------
    logic [S1_W-1:0] w_s1_in;
    logic [S1_W-1:0] w_s1_out;
    logic            w_s1_valid;
    logic            w_s1_ready;

    assign w_s1_in = {bus.dec_in_code,
                      R'(syndrome(MAX_CW'(bus.dec_in_code), N)),
                      ^bus.dec_in_code};

    secded_pipe_reg #(.WIDTH(S1_W)) u_dec_s1_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.dec_in_valid),
        .in_ready  (bus.dec_in_ready),
        .in_data   (w_s1_in),
        .out_valid (w_s1_valid),
        .out_ready (w_s1_ready),
        .out_data  (w_s1_out)
    );

    // ---------------- decode stage 2: correct and classify ----------------
    logic [CW-1:0]     w_s1_code;
    logic [R-1:0]      w_s1_syn;
    logic              w_s1_q;
    logic [1:0]        w_cls;
    logic [CW-1:0]     w_fix_code;
    logic [DATA_W-1:0] w_dec_data;
    logic [S2_W-1:0]   w_s2_in;
    logic [S2_W-1:0]   w_s2_out;

    assign w_s1_code = w_s1_out[S1_W-1 -: CW];
    assign w_s1_syn  = w_s1_out[R:1];
    assign w_s1_q    = w_s1_out[0];
    assign w_cls     = classify(MAX_R'(w_s1_syn), w_s1_q, N);

    // Flip the Hamming position named by the syndrome; a bit-0 error needs no data fix
    always_comb begin
        w_fix_code = w_s1_code;
        for (int p = 1; p < CW; p++) begin
            if (w_cls == CLS_CORRECTED && w_s1_syn == R'(p)) w_fix_code[p] = ~w_s1_code[p];
        end
    end

    assign w_dec_data = DATA_W'(extract(MAX_CW'(w_fix_code), DATA_W));
    assign w_s2_in    = {w_dec_data, w_s1_syn,
                         w_cls == CLS_CORRECTED, w_cls == CLS_UNCORRECTABLE};

    secded_pipe_reg #(.WIDTH(S2_W)) u_dec_s2_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s1_ready),
        .in_data   (w_s2_in),
        .out_valid (bus.dec_out_valid),
        .out_ready (bus.dec_out_ready),
        .out_data  (w_s2_out)
    );

    assign bus.dec_out_data          = w_s2_out[S2_W-1 -: DATA_W];
    assign bus.dec_out_syndrome      = w_s2_out[R+1:2];
    assign bus.dec_out_corrected     = w_s2_out[1];
    assign bus.dec_out_uncorrectable = w_s2_out[0];

    // ---------------- statistics ----------------
    logic             w_dec_xfer;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    assign w_dec_xfer     = bus.dec_out_valid & bus.dec_out_ready;
    assign bus.corr_cnt   = r_corr_cnt;
    assign bus.uncorr_cnt = r_uncorr_cnt;

    // Count accepted corrected words; clear wins, counter sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_corr_cnt <= '0;
        end else if (w_dec_xfer && bus.dec_out_corrected && r_corr_cnt != '1) begin
            r_corr_cnt <= r_corr_cnt + 1'b1;
        end
    end

    // Count accepted uncorrectable words; clear wins, counter sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uncorr_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_uncorr_cnt <= '0;
        end else if (w_dec_xfer && bus.dec_out_uncorrectable && r_uncorr_cnt != '1) begin
            r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_secded_codec_pipe.sv
`default_nettype none
// ============================================================================
// tb_secded_codec_pipe
// Directed-vector bench for the SECDED codec, DATA_W=4 and CNT_W=2.
// Revision: 1.0 - initial release
// ============================================================================
module tb_secded_codec_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    secded_codec_pipe_if #(.DATA_W(4), .CNT_W(2)) bus ();

    secded_codec_pipe #(.DATA_W(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Send one word through the encoder and capture its output
    task automatic enc_xfer(input logic [3:0] d, input logic [7:0] inj,
                            output logic v, output logic [7:0] code);
        @(negedge clk);
        bus.enc_in_valid  = 1'b1;
        bus.enc_in_data   = d;
        bus.enc_in_inject = inj;
        @(negedge clk);
        v    = bus.enc_out_valid;
        code = bus.enc_out_code;
        bus.enc_in_valid = 1'b0;
    endtask

    // Send one codeword through the decoder, capture output, let it drain
    task automatic dec_xfer(input logic [7:0] code, output logic v, output logic [3:0] d,
                            output logic [2:0] s, output logic c, output logic u);
        @(negedge clk);
        bus.dec_in_valid = 1'b1;
        bus.dec_in_code  = code;
        @(negedge clk);
        bus.dec_in_valid = 1'b0;
        @(negedge clk);
        v = bus.dec_out_valid;
        d = bus.dec_out_data;
        s = bus.dec_out_syndrome;
        c = bus.dec_out_corrected;
        u = bus.dec_out_uncorrectable;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.enc_out_valid !== 1'b0) begin failures++; $display("FAIL reset_enc_valid got=%b exp=0", bus.enc_out_valid); end
        checks++; if (bus.dec_out_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", bus.dec_out_valid); end
        checks++; if (bus.enc_out_code !== 8'h00) begin failures++; $display("FAIL reset_enc_code got=%h exp=00", bus.enc_out_code); end
        checks++; if (bus.dec_out_data !== 4'h0) begin failures++; $display("FAIL reset_dec_data got=%h exp=0", bus.dec_out_data); end
        checks++; if (bus.dec_out_syndrome !== 3'b000) begin failures++; $display("FAIL reset_syndrome got=%b exp=000", bus.dec_out_syndrome); end
        checks++; if ({bus.dec_out_corrected, bus.dec_out_uncorrectable} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.dec_out_corrected, bus.dec_out_uncorrectable); end
        checks++; if (bus.corr_cnt !== 2'd0 || bus.uncorr_cnt !== 2'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.corr_cnt, bus.uncorr_cnt); end
        checks++; if (bus.enc_in_ready !== 1'b1 || bus.dec_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b%b exp=11", bus.enc_in_ready, bus.dec_in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_encode();
        logic       v;
        logic [7:0] code;
        enc_xfer(4'b1011, 8'h00, v, code);
        checks++; if (v !== 1'b1 || code !== 8'hAA) begin failures++; $display("FAIL encode_1011 got=v%b/%h exp=v1/aa", v, code); end
        @(negedge clk);
        checks++; if (bus.enc_out_valid !== 1'b0) begin failures++; $display("FAIL encode_drain got=%b exp=0", bus.enc_out_valid); end
        enc_xfer(4'b1000, 8'h00, v, code);
        checks++; if (code !== 8'h96) begin failures++; $display("FAIL encode_1000 got=%h exp=96", code); end
    endtask

    task automatic test_round_trip();
        logic v, c, u;
        logic [3:0] d;
        logic [2:0] s;
        dec_xfer(8'hAA, v, d, s, c, u);
        checks++; if (v !== 1'b1 || d !== 4'b1011) begin failures++; $display("FAIL round_trip_data got=v%b/%b exp=v1/1011", v, d); end
        checks++; if (s !== 3'b000 || c !== 1'b0 || u !== 1'b0) begin failures++; $display("FAIL round_trip_flags got=s%b c%b u%b exp=s000 c0 u0", s, c, u); end
        checks++; if (bus.corr_cnt !== 2'd0 || bus.uncorr_cnt !== 2'd0) begin failures++; $display("FAIL round_trip_counters got=%0d/%0d exp=0/0", bus.corr_cnt, bus.uncorr_cnt); end
    endtask

    task automatic test_single_error();
        logic ev, v, c, u;
        logic [7:0] code;
        logic [3:0] d;
        logic [2:0] s;
        enc_xfer(4'b1011, 8'h40, ev, code);
        checks++; if (code !== 8'hEA) begin failures++; $display("FAIL single_inject_code got=%h exp=ea", code); end
        dec_xfer(code, v, d, s, c, u);
        checks++; if (d !== 4'b1011 || s !== 3'b110) begin failures++; $display("FAIL single_data_syn got=%b/%b exp=1011/110", d, s); end
        checks++; if (c !== 1'b1 || u !== 1'b0) begin failures++; $display("FAIL single_flags got=c%b u%b exp=c1 u0", c, u); end
        checks++; if (bus.corr_cnt !== 2'd1) begin failures++; $display("FAIL single_corr_cnt got=%0d exp=1", bus.corr_cnt); end
        // Error confined to the overall parity bit
        dec_xfer(8'hAB, v, d, s, c, u);
        checks++; if (d !== 4'b1011 || s !== 3'b000 || c !== 1'b1 || u !== 1'b0) begin failures++; $display("FAIL bit0_error got=%b s%b c%b u%b exp=1011 s000 c1 u0", d, s, c, u); end
        checks++; if (bus.corr_cnt !== 2'd2) begin failures++; $display("FAIL bit0_corr_cnt got=%0d exp=2", bus.corr_cnt); end
    endtask

    task automatic test_double_error();
        logic ev, v, c, u;
        logic [7:0] code;
        logic [3:0] d;
        logic [2:0] s;
        enc_xfer(4'b1011, 8'h28, ev, code);
        checks++; if (code !== 8'h82) begin failures++; $display("FAIL double_inject_code got=%h exp=82", code); end
        dec_xfer(code, v, d, s, c, u);
        checks++; if (d !== 4'b1000 || s !== 3'b110) begin failures++; $display("FAIL double_data_syn got=%b/%b exp=1000/110", d, s); end
        checks++; if (c !== 1'b0 || u !== 1'b1) begin failures++; $display("FAIL double_flags got=c%b u%b exp=c0 u1", c, u); end
        checks++; if (bus.uncorr_cnt !== 2'd1 || bus.corr_cnt !== 2'd2) begin failures++; $display("FAIL double_counters got=%0d/%0d exp=2/1", bus.corr_cnt, bus.uncorr_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] din  [4] = '{4'h0, 4'h1, 4'h2, 4'hF};
        logic [7:0] dexp [4] = '{8'h00, 8'h0F, 8'h33, 8'hFF};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.enc_out_valid !== 1'b1 || bus.enc_out_code !== dexp[i-1]) begin
                    failures++; $display("FAIL b2b_word%0d got=v%b/%h exp=v1/%h", i-1, bus.enc_out_valid, bus.enc_out_code, dexp[i-1]);
                end
            end
            if (i < 4) begin
                bus.enc_in_valid  = 1'b1;
                bus.enc_in_data   = din[i];
                bus.enc_in_inject = 8'h00;
            end else begin
                bus.enc_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] codes [4] = '{8'h0F, 8'h33, 8'hFF, 8'h96};
        logic [3:0] datas [4] = '{4'h1, 4'h2, 4'hF, 4'h8};
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        int sent_at_fall = -1;
        bit stall_bad = 1'b0;
        while (rcvd < 4 && cyc < 40) begin
            @(negedge clk);
            bus.dec_out_ready = (cyc >= 7);
            bus.dec_in_valid  = (sent < 4);
            bus.dec_in_code   = codes[(sent < 4) ? sent : 0];
            #1;
            if (sent_at_fall < 0 && !bus.dec_in_ready) sent_at_fall = sent;
            if (cyc >= 2 && cyc < 7) begin
                if (bus.dec_out_valid !== 1'b1 || bus.dec_out_data !== 4'h1 || bus.dec_in_ready !== 1'b0) stall_bad = 1'b1;
            end
            if (bus.dec_out_valid && bus.dec_out_ready) begin
                checks++;
                if (bus.dec_out_data !== datas[rcvd]) begin
                    failures++; $display("FAIL bp_order word%0d got=%h exp=%h", rcvd, bus.dec_out_data, datas[rcvd]);
                end
                rcvd++;
            end
            if (bus.dec_in_valid && bus.dec_in_ready) sent++;
            cyc++;
        end
        bus.dec_in_valid  = 1'b0;
        bus.dec_out_ready = 1'b1;
        checks++; if (sent_at_fall != 2) begin failures++; $display("FAIL bp_ready_fall got=%0d exp=2", sent_at_fall); end
        checks++; if (stall_bad) begin failures++; $display("FAIL bp_stall_hold got=unstable exp=stable"); end
        checks++; if (rcvd != 4) begin failures++; $display("FAIL bp_received got=%0d exp=4", rcvd); end
        checks++; if (bus.corr_cnt !== 2'd2 || bus.uncorr_cnt !== 2'd1) begin failures++; $display("FAIL bp_counters got=%0d/%0d exp=2/1", bus.corr_cnt, bus.uncorr_cnt); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus.enc_out_ready = 1'b0;
        bus.dec_out_ready = 1'b0;
        bus.enc_in_valid  = 1'b1;
        bus.enc_in_data   = 4'h1;
        bus.enc_in_inject = 8'h00;
        bus.dec_in_valid  = 1'b1;
        bus.dec_in_code   = 8'hEA;
        repeat (2) @(negedge clk);
        bus.enc_in_valid = 1'b0;
        bus.dec_in_valid = 1'b0;
        checks++; if (bus.enc_out_valid !== 1'b1 || bus.dec_out_valid !== 1'b1) begin failures++; $display("FAIL midflight_loaded got=%b%b exp=11", bus.enc_out_valid, bus.dec_out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.enc_out_valid !== 1'b0 || bus.dec_out_valid !== 1'b0) begin failures++; $display("FAIL midflight_async_clear got=%b%b exp=00", bus.enc_out_valid, bus.dec_out_valid); end
        checks++; if (bus.corr_cnt !== 2'd0 || bus.uncorr_cnt !== 2'd0) begin failures++; $display("FAIL midflight_counters got=%0d/%0d exp=0/0", bus.corr_cnt, bus.uncorr_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.enc_out_ready = 1'b1;
        bus.dec_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.enc_out_valid !== 1'b0 || bus.dec_out_valid !== 1'b0) begin failures++; $display("FAIL midflight_no_output got=%b%b exp=00", bus.enc_out_valid, bus.dec_out_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.dec_in_valid = 1'b1;
            bus.dec_in_code  = 8'hEA;
        end
        @(negedge clk);
        bus.dec_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.corr_cnt !== 2'd3) begin failures++; $display("FAIL saturate_corr_cnt got=%0d exp=3", bus.corr_cnt); end
        checks++; if (bus.uncorr_cnt !== 2'd0) begin failures++; $display("FAIL saturate_uncorr_cnt got=%0d exp=0", bus.uncorr_cnt); end
    endtask

    task automatic test_clear();
        logic v, c, u;
        logic [3:0] d;
        logic [2:0] s;
        @(negedge clk);
        bus.dec_in_valid = 1'b1;
        bus.dec_in_code  = 8'hEA;
        @(negedge clk);
        bus.dec_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.dec_out_valid !== 1'b1 || bus.dec_out_corrected !== 1'b1) begin failures++; $display("FAIL clear_setup got=v%b c%b exp=v1 c1", bus.dec_out_valid, bus.dec_out_corrected); end
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        checks++; if (bus.corr_cnt !== 2'd0) begin failures++; $display("FAIL clear_wins got=%0d exp=0", bus.corr_cnt); end
        dec_xfer(8'hEA, v, d, s, c, u);
        checks++; if (bus.corr_cnt !== 2'd1) begin failures++; $display("FAIL clear_recount got=%0d exp=1", bus.corr_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.enc_in_valid  = 1'b0;
        bus.enc_in_data   = '0;
        bus.enc_in_inject = '0;
        bus.enc_out_ready = 1'b1;
        bus.dec_in_valid  = 1'b0;
        bus.dec_in_code   = '0;
        bus.dec_out_ready = 1'b1;
        bus.cnt_clr       = 1'b0;
        test_reset();
        test_encode();
        test_round_trip();
        test_single_error();
        test_double_error();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
